// File: rtl/quant_pkg.sv
// quant_pkg: shared constants, types and the round/saturate helper for the
// quant_gain_requant block.
//   - *_DEF localparams : default values of the block's parameters
//   - dout_t            : packed {re, im} output word at the default width
//   - sat_res_t         : result of sat_round (clipped value + saturation flag)
//   - sat_round()       : half-up rounding right shift followed by symmetric
//                         saturation to DOUT_W_DEF bits
package quant_pkg;

  localparam int          DIN_W_DEF     = 18;
  localparam int          DOUT_W_DEF    = 4;
  localparam int          GAIN_FRAC_DEF = 12;
  localparam int          DIN_SHIFT_DEF = 14;
  localparam logic [15:0] GAIN_RST_DEF  = 16'h1000;

  // Gain is an unsigned 16-bit word, multiplied as a 17-bit signed operand.
  localparam int GAIN_W = 16;
  localparam int PROD_W = DIN_W_DEF + GAIN_W + 1;
  // One guard bit so adding the rounding constant can never overflow.
  localparam int PROD_X = PROD_W + 1;
  // Symmetric limit: the most negative code is never produced.
  localparam int OUT_MAX = (2 ** (DOUT_W_DEF - 1)) - 1;

  typedef struct packed {
    logic signed [DOUT_W_DEF-1:0] re;
    logic signed [DOUT_W_DEF-1:0] im;
  } dout_t;

  typedef struct packed {
    logic signed [DOUT_W_DEF-1:0] q;
    logic                         sat;
  } sat_res_t;

  // Round half-up (add 2^(shift-1), arithmetic shift right) and clip to
  // +/-OUT_MAX. shift must be >= 1 and is a constant at every call site.
  function automatic sat_res_t sat_round(input logic signed [PROD_W-1:0] prod,
                                         input int shift);
    logic signed [PROD_X-1:0] half;
    logic signed [PROD_X-1:0] sum;
    logic signed [PROD_X-1:0] r;
    logic signed [PROD_X-1:0] lim;
    sat_res_t                 res;
    half            = '0;
    half[shift - 1] = 1'b1;
    lim             = PROD_X'(OUT_MAX);
    sum             = PROD_X'(prod) + half;
    r               = sum >>> shift;
    if (r > lim) begin
      res.q   = DOUT_W_DEF'(OUT_MAX);
      res.sat = 1'b1;
    end else if (r < -lim) begin
      res.q   = DOUT_W_DEF'(-OUT_MAX);
      res.sat = 1'b1;
    end else begin
      res.q   = r[DOUT_W_DEF-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/quant_gain_requant_if.sv
// quant_gain_requant_if: bundle of the sample stream around quant_gain_requant.
// Stream semantics: valid-only, no ready. A sample is transferred on every
// rising clock edge where valid is 1; the receiver must always accept it.
// sync marks the start of a spectrum and is independent of valid.
//   master : drives gain, sync_in, valid_in, din_re, din_im; observes outputs
//   slave  : the requantiser side (consumes inputs, drives outputs)
interface quant_gain_requant_if
  import quant_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
);
  logic [31:0]             gain;
  logic                    sync_in;
  logic                    valid_in;
  logic signed [DIN_W-1:0] din_re;
  logic signed [DIN_W-1:0] din_im;
  logic                    sync_out;
  logic                    valid_out;
  logic [2*DOUT_W-1:0]     dout;
  logic [31:0]             sat_count;

  modport master (
    output gain, sync_in, valid_in, din_re, din_im,
    input  sync_out, valid_out, dout, sat_count
  );

  modport slave (
    input  gain, sync_in, valid_in, din_re, din_im,
    output sync_out, valid_out, dout, sat_count
  );
endinterface

// File: rtl/quant_cplx_lane.sv
// quant_cplx_lane: one real or imaginary component of the requantiser.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : stage-1 registered sample component (signed)
//   gain       : stage-1 active gain (unsigned, GAIN_FRAC fractional bits)
//   load       : stage-2 valid; the rounded result is registered only then
//   q          : stage-3 result, holds its value when load is 0
//   sat        : stage-2 combinational flag, result of this product clipped
module quant_cplx_lane
  import quant_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT  = GAIN_FRAC_DEF + DIN_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DIN_W-1:0]  din,
  input  logic [GAIN_W-1:0]        gain,
  input  logic                     load,
  output logic signed [DOUT_W-1:0] q,
  output logic                     sat
);

  localparam int P_W = DIN_W + GAIN_W + 1;

  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] din_x;
  logic signed [P_W-1:0] gain_x;
  sat_res_t              res;

  // Both operands widened to the full product width before multiplying so no
  // bits are lost; the gain gets a zero sign bit to stay non-negative.
  assign din_x  = P_W'(din);
  assign gain_x = P_W'($signed({1'b0, gain}));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod <= '0;
    end else begin
      prod <= din_x * gain_x;
    end
  end

  always_comb begin
    res = sat_round(PROD_W'(prod), SHIFT);
  end

  assign sat = res.sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= DOUT_W'(res.q);
    end
  end

endmodule

// File: rtl/quant_gain_requant.sv
// quant_gain_requant: complex sample gain and requantisation to DOUT_W bits.
// Three-stage pipeline, no backpressure:
//   stage 1 : input registers, active gain (loaded only on sync_in)
//   stage 2 : full-width multiply (inside each lane)
//   stage 3 : half-up rounding and symmetric saturation (inside each lane)
// Ports:
//   user_clk, user_rst_n : clock, synchronous active-low reset
//   gain_in              : [15:0] unsigned gain, [31:16] ignored
//   sync_in, valid_in    : spectrum start, sample valid (independent)
//   din_re, din_im       : signed input components
//   sync_out, valid_out  : inputs delayed by 3 cycles
//   dout                 : {re, im}, holds its value when valid_out is 0
//   sat_count            : saturated components of the last completed window
// Optional feature macro: QUANT_SAT_COUNT_EN enables the saturation window
// counter; without it sat_count is tied to 0.
module quant_gain_requant
  import quant_pkg::*;
#(
  parameter int          DIN_W     = DIN_W_DEF,
  parameter int          DOUT_W    = DOUT_W_DEF,
  parameter int          GAIN_FRAC = GAIN_FRAC_DEF,
  parameter int          DIN_SHIFT = DIN_SHIFT_DEF,
  parameter logic [15:0] GAIN_RST  = GAIN_RST_DEF
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  input  logic [31:0]             gain_in,
  input  logic                    sync_in,
  input  logic                    valid_in,
  input  logic signed [DIN_W-1:0] din_re,
  input  logic signed [DIN_W-1:0] din_im,
  output logic                    sync_out,
  output logic                    valid_out,
  output logic [2*DOUT_W-1:0]     dout,
  output logic [31:0]             sat_count
);

  localparam int SHIFT = GAIN_FRAC + DIN_SHIFT;

  logic                    s1_valid;
  logic                    s1_sync;
  logic                    s2_valid;
  logic                    s2_sync;
  logic signed [DIN_W-1:0] s1_re;
  logic signed [DIN_W-1:0] s1_im;
  logic [GAIN_W-1:0]       gain_act;
  logic signed [DOUT_W-1:0] q_re;
  logic signed [DOUT_W-1:0] q_im;
  logic                    sat_re;
  logic                    sat_im;
  logic                    unused_gain_hi;

  assign unused_gain_hi = ^gain_in[31:16];

  // Control pipeline. The gain register loads in the same edge as the
  // sync-coincident sample, so that sample already sees the new gain.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      s1_valid  <= 1'b0;
      s1_sync   <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      gain_act  <= GAIN_RST;
      s2_valid  <= 1'b0;
      s2_sync   <= 1'b0;
      valid_out <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      s1_valid  <= valid_in;
      s1_sync   <= sync_in;
      s1_re     <= din_re;
      s1_im     <= din_im;
      if (sync_in) begin
        gain_act <= gain_in[GAIN_W-1:0];
      end
      s2_valid  <= s1_valid;
      s2_sync   <= s1_sync;
      valid_out <= s2_valid;
      sync_out  <= s2_sync;
    end
  end

  quant_cplx_lane #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .SHIFT  (SHIFT)
  ) u_lane_re (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .din   (s1_re),
    .gain  (gain_act),
    .load  (s2_valid),
    .q     (q_re),
    .sat   (sat_re)
  );

  quant_cplx_lane #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .SHIFT  (SHIFT)
  ) u_lane_im (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .din   (s1_im),
    .gain  (gain_act),
    .load  (s2_valid),
    .q     (q_im),
    .sat   (sat_im)
  );

  assign dout = {q_re, q_im};

`ifdef QUANT_SAT_COUNT_EN
  logic [31:0] win_cnt;
  logic [31:0] sat_cnt_q;
  logic [1:0]  sat_inc;
  logic [32:0] win_sum;

  // Counted in the edge that registers the sample into dout, so the window
  // boundary lines up exactly with sync_out.
  assign sat_inc = s2_valid ? ({1'b0, sat_re} + {1'b0, sat_im}) : 2'd0;
  assign win_sum = {1'b0, win_cnt} + {31'd0, sat_inc};

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      win_cnt   <= '0;
      sat_cnt_q <= '0;
    end else if (s2_sync) begin
      // Close the window; the sync-coincident sample opens the new one.
      sat_cnt_q <= win_cnt;
      win_cnt   <= {30'd0, sat_inc};
    end else begin
      win_cnt   <= win_sum[32] ? 32'hFFFF_FFFF : win_sum[31:0];
    end
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_sat;

  assign unused_sat = sat_re | sat_im;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_quant_gain_requant.sv
// tb_quant_gain_requant: directed stimulus for quant_gain_requant, checked
// every cycle against an arithmetic model and at key points against
// hand-computed dout / sat_count values.
module tb_quant_gain_requant;
  import quant_pkg::*;

  localparam int     DW  = 18;
  localparam int     OW  = 4;
  localparam int     SH  = 26;
  localparam longint LIM = 7;
`ifdef QUANT_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quant_gain_requant_if #(.DIN_W(DW), .DOUT_W(OW)) bus ();

  quant_gain_requant dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .gain_in    (bus.gain),
    .sync_in    (bus.sync_in),
    .valid_in   (bus.valid_in),
    .din_re     (bus.din_re),
    .din_im     (bus.din_im),
    .sync_out   (bus.sync_out),
    .valid_out  (bus.valid_out),
    .dout       (bus.dout),
    .sat_count  (bus.sat_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit     v;
    bit     s;
    longint re;
    longint im;
    longint sats;
  } ent_t;

  ent_t        p1, p2;
  longint      m_gain = 64'h1000;
  bit          m_valid = 1'b0;
  bit          m_sync = 1'b0;
  dout_t       m_dout = '0;
  longint      m_win = 0;
  logic [31:0] m_satc = '0;
  bit          m_ready = 1'b0;

  // q = round_half_up(d * g / 2^26), clipped to +/-7.
  function automatic longint requant(input longint d, input longint g, output longint sat);
    longint r;
    r   = (d * g + (longint'(1) <<< (SH - 1))) >>> SH;
    sat = 0;
    if (r > LIM) begin
      r   = LIM;
      sat = 1;
    end else if (r < -LIM) begin
      r   = -LIM;
      sat = 1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    ent_t   e;
    longint s_re, s_im;
    if (!rst_n) begin
      p1.v = 0; p1.s = 0; p2.v = 0; p2.s = 0;
      m_gain  = 64'h1000;
      m_valid = 0;
      m_sync  = 0;
      m_dout  = '0;
      m_win   = 0;
      m_satc  = '0;
      m_ready = 1'b1;
    end else begin
      if (bus.sync_in) m_gain = longint'(bus.gain[15:0]);
      e.v    = bus.valid_in;
      e.s    = bus.sync_in;
      e.re   = requant(longint'(bus.din_re), m_gain, s_re);
      e.im   = requant(longint'(bus.din_im), m_gain, s_im);
      e.sats = s_re + s_im;
      m_valid = p2.v;
      m_sync  = p2.s;
      if (p2.v) begin
        m_dout.re = 4'(p2.re);
        m_dout.im = 4'(p2.im);
      end
      if (p2.s) begin
        m_satc = 32'(m_win);
        m_win  = p2.v ? p2.sats : 0;
      end else if (p2.v) begin
        m_win = m_win + p2.sats;
        if (m_win > 64'hFFFF_FFFF) m_win = 64'hFFFF_FFFF;
      end
      p2 = p1;
      p1 = e;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_ready) begin
      check("valid_out", 32'(bus.valid_out), 32'(m_valid));
      check("sync_out", 32'(bus.sync_out), 32'(m_sync));
      check("dout", 32'(bus.dout), 32'(m_dout));
      check("sat_count", bus.sat_count, SAT_EN ? m_satc : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit s, input int re, input int im, input logic [31:0] g);
    bus.valid_in = v;
    bus.sync_in  = s;
    bus.din_re   = DW'(re);
    bus.din_im   = DW'(im);
    bus.gain     = g;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    bus.sync_in  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Literal dout check on the DUT and on the model.
  task automatic lit(input string name, input logic [7:0] exp_dout);
    check({name, "_dut"}, 32'(bus.dout), 32'(exp_dout));
    check({name, "_model"}, 32'(m_dout), 32'(exp_dout));
  endtask

  logic [15:0] burst_gain [3] = '{16'h1000, 16'h0800, 16'h3000};

  initial begin
    bus.valid_in = 1'b0;
    bus.sync_in  = 1'b0;
    bus.din_re   = '0;
    bus.din_im   = '0;
    bus.gain     = 32'h0000_1000;
    repeat (3) @(negedge clk);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_sync_out", 32'(bus.sync_out), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_sat_count", bus.sat_count, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Scaling: +1 / -1, exactly three cycles after valid_in.
    drive(1, 1, 16384, -16384, 32'h0000_1000);
    idle(1);
    check("lat_early_valid", 32'(bus.valid_out), 32'd0);
    idle(1);
    check("lat_valid", 32'(bus.valid_out), 32'd1);
    lit("scale", 8'h1F);
    // Rounding: +0.5 -> +1, -0.5 -> 0.
    drive(1, 0, 8192, -8192, 32'h0000_1000);
    idle(2);
    lit("round", 8'h10);
    // Saturation: +7 / -7, two saturated components.
    drive(1, 0, 131071, -131072, 32'h0000_1000);
    idle(2);
    lit("sat", 8'h79);
    // Gain word changes between syncs: no effect.
    drive(1, 0, 16384, 0, 32'h0000_2000);
    idle(2);
    lit("gain_hold", 8'h10);
    // Sync-coincident sample uses the new gain; window closes with 2 sats.
    drive(1, 1, 16384, -16384, 32'h0000_2000);
    idle(2);
    lit("gain_new", 8'h2E);
    check("sat_window", bus.sat_count, SAT_EN ? 32'd2 : 32'd0);
    // Sync without valid still reaches sync_out; loads gain 0.
    drive(0, 1, 0, 0, 32'h0000_0000);
    idle(2);
    check("sync_only_sync", 32'(bus.sync_out), 32'd1);
    check("sync_only_valid", 32'(bus.valid_out), 32'd0);
    drive(1, 0, 131071, -131072, 32'h0000_0000);
    idle(2);
    lit("gain_zero", 8'h00);
    // Maximum gain: no product overflow.
    drive(1, 1, 131071, -131072, 32'h1234_FFFF);
    drive(1, 0, 1024, -2048, 32'h0000_FFFF);
    idle(1);
    lit("gain_max_sat", 8'h79);
    idle(1);
    lit("gain_max_small", 8'h1E);
    idle(2);

    // Window counter saturation.
    drive(1, 1, 0, 0, 32'h0000_1000);
    idle(3);
`ifdef QUANT_SAT_COUNT_EN
    force dut.win_cnt = 32'hFFFF_FFFE;
    m_win = 64'hFFFF_FFFE;
    #1;
    release dut.win_cnt;
`endif
    drive(1, 0, 131071, -131072, 32'h0000_1000);
    drive(1, 0, 131071, 0, 32'h0000_1000);
    drive(0, 1, 0, 0, 32'h0000_1000);
    idle(2);
    check("cnt_sat", bus.sat_count, SAT_EN ? 32'hFFFF_FFFF : 32'd0);
    idle(2);

    // Burst: gaps in valid, syncs with and without valid, junk gain between syncs.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] g;
      bit          s;
      s = (i % 8 == 0);
      g = s ? {16'hFFFF, burst_gain[i / 8]} : (32'hABCD_0000 | 32'(i * 1234));
      drive(i % 5 != 3, s, ((i * 37117) % 262143) - 131071,
            ((i * 52711 + 999) % 262143) - 131071, g);
    end
    drive(0, 1, 0, 0, 32'h0000_2000);
    idle(4);

    // Reset for one cycle during valid traffic.
    drive(1, 1, 16384, -16384, 32'h0000_2000);
    drive(1, 0, 131071, -131072, 32'h0000_2000);
    drive(1, 0, 8192, 8192, 32'h0000_2000);
    bus.valid_in = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    check("mid_rst_valid", 32'(bus.valid_out), 32'd0);
    check("mid_rst_dout", 32'(bus.dout), 32'd0);
    check("mid_rst_sat_count", bus.sat_count, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("post_rst_no_valid", 32'(bus.valid_out), 32'd0);
    end
    // Active gain is back to 1.0 even though gain_in says 2.0.
    drive(1, 0, 16384, 0, 32'h0000_2000);
    idle(2);
    lit("post_rst_gain", 8'h10);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/quant_gain_requant.md
QUANT_GAIN_REQUANT -- requirements
Module: quant_gain_requant

Interface
REQ-001 SHALL have parameter DIN_W, default 18: signed width of each input real/imag component.
REQ-002 SHALL have parameter DOUT_W, default 4: signed width of each output real/imag component.
REQ-003 SHALL have parameter GAIN_FRAC, default 12: fractional bits of gain, so 0x1000 = 1.0.
REQ-004 SHALL have parameter DIN_SHIFT, default 14: extra right shift applied to the product.
REQ-005 SHALL have parameter GAIN_RST, default 16'h1000: active gain after reset.
REQ-006 SHALL have port user_clk, input, 1 bit: the single clock; reset is synchronous and active-low.
REQ-007 SHALL have port user_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port gain_in, input, 32 bits: software gain word; bits [15:0] are unsigned gain, bits [31:16] are ignored.
REQ-009 SHALL have port sync_in, input, 1 bit: spectrum-start pulse; it may coincide with valid_in.
REQ-010 SHALL have port valid_in, input, 1 bit: din_re and din_im are valid this cycle.
REQ-011 SHALL have ports din_re and din_im, input, DIN_W bits each, signed.
REQ-012 SHALL have port sync_out, output, 1 bit: sync_in delayed to align with the data.
REQ-013 SHALL have port valid_out, output, 1 bit.
REQ-014 SHALL have port dout, output, 2*DOUT_W bits, packed {re, im}, each two's complement.
REQ-015 SHALL have port sat_count, output, 32 bits: saturation count of the last completed window.

Function
REQ-016 Each component SHALL compute q = round(din * g / 2^(GAIN_FRAC+DIN_SHIFT)), where g is the active gain.
REQ-017 Rounding SHALL be half-up: add 2^(GAIN_FRAC+DIN_SHIFT-1), then arithmetic right shift.
REQ-018 The product SHALL be computed at full DIN_W+17 bit signed width, with no intermediate truncation.
REQ-019 Saturation SHALL be symmetric: results above +(2^(DOUT_W-1)-1) clip to that value; results below -(2^(DOUT_W-1)-1) clip to its negative (for 4 bits, +7 and -7; -8 is never produced).
REQ-020 Latency SHALL be exactly 3 cycles for all of the following: valid_in to valid_out, sync_in to sync_out, and data to dout.
  - stage 1: input and gain registers
  - stage 2: multiply
  - stage 3: round and saturate
REQ-021 The pipeline SHALL advance every cycle; there is no backpressure.
REQ-022 valid and sync SHALL propagate independently; sync_out fires even when valid_in is 0.
REQ-023 When valid_out=0, dout SHALL hold its last value.
REQ-024 The active gain SHALL load from gain_in[15:0] only in a cycle where sync_in=1.
REQ-025 The sample arriving in the same cycle as sync_in SHALL use the new gain.
REQ-026 Changes to gain_in between syncs SHALL have no effect on the output.
REQ-027 gain = 0 SHALL yield dout = 0.
REQ-028 The maximum gain 0xFFFF SHALL not overflow the product.

Reset
REQ-029 While user_rst_n=0 at a rising edge, the following SHALL clear: valid_out=0, sync_out=0, dout=0, sat_count=0, the window counter=0, and all pipeline valid/sync bits.
REQ-030 Reset SHALL set the active gain to GAIN_RST.
REQ-031 Reset asserted mid-window SHALL discard the in-flight samples and the partial count; the first sync_in after release starts a fresh window.

Configuration
REQ-032 With macro QUANT_SAT_COUNT_EN defined, the block SHALL count saturated components per valid sample: +0, +1 or +2 (re and im counted separately).
REQ-033 The window counter SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-034 On sync_out, the window counter SHALL be copied to sat_count and restart.
  - restart value is 0, plus that cycle's saturations if valid_out=1
REQ-035 Without QUANT_SAT_COUNT_EN, sat_count SHALL be constant 0, and the counter logic SHALL be absent.

Structure
REQ-036 Package quant_pkg SHALL hold the default parameter constants, the packed output typedef and the function sat_round(product) -> DOUT_W.
REQ-037 One sub-module SHALL be used: quant_cplx_lane (one component's multiply, round and saturate), instantiated twice.

Verification
REQ-038 Scaling: gain=0x1000, sync, din_re=16384, din_im=-16384 -> dout re=+1, im=-1, exactly 3 cycles after valid_in.
REQ-039 Rounding: din_re=8192, din_im=-8192, gain=1.0 -> re=+1 (0.5 rounds up), im=0 (-0.5 rounds to 0).
REQ-040 Saturation: din_re=131071, din_im=-131072, gain=1.0 -> re=+7, im=-7; with QUANT_SAT_COUNT_EN, sat_count=2 after the next sync_out.
REQ-041 Gain timing: gain_in changes to 0x2000 mid-window -> output scale unchanged until sync_in; the sync-coincident sample with din_re=16384 -> re=+2.
REQ-042 Counter saturation: with QUANT_SAT_COUNT_EN, preload or force the window counter to 0xFFFFFFFE, apply 3 saturated components -> sat_count=0xFFFFFFFF at sync_out.
REQ-043 Reset mid-stream: assert user_rst_n=0 for 1 cycle during valid traffic -> next cycle outputs are 0, active gain is 0x1000 and sat_count=0; no stale valid_out appears afterward.
